// File: rtl/mem_access_stage_pkg.sv
// Shared width encodings and depth default for the MEM stage.
package mem_access_stage_pkg;

   localparam logic [1:0] MEM_BYTE = 2'b00;
   localparam logic [1:0] MEM_HALF = 2'b01;
   localparam logic [1:0] MEM_WORD = 2'b11;

   localparam int DEFAULT_NB_MEM_ADDR = 8;

endpackage

// File: rtl/mem_access_stage_load_store_align.sv
// Byte-lane steering for stores, lane select and extension for loads,
// plus alignment checking. Purely combinational.
module load_store_align
   import mem_access_stage_pkg::*;
#(
   parameter int NB_DATA = 32
) (
   input  logic [1:0]           i_addr,
   input  logic [1:0]           i_width,
   input  logic                 i_unsigned,
   input  logic                 i_access,
   input  logic [NB_DATA-1:0]   i_store_data,
   input  logic [NB_DATA-1:0]   i_rdata,
   output logic [NB_DATA/8-1:0] o_be,
   output logic [NB_DATA-1:0]   o_wdata,
   output logic [NB_DATA-1:0]   o_rdata,
   output logic                 o_misaligned
);

   logic                w_byte;
   logic                w_half;
   logic                w_word;
   logic [NB_DATA-1:0]  w_shifted;
   logic [7:0]          w_lane_b;
   logic [15:0]         w_lane_h;

   assign w_byte = (i_width == MEM_BYTE);
   assign w_half = (i_width == MEM_HALF);
   // 2'b10 falls through to word
   assign w_word = !w_byte && !w_half;

   assign o_misaligned = i_access &&
      ((w_half && i_addr[0]) || (w_word && (i_addr != 2'b00)));

   assign w_shifted = i_rdata >> {i_addr, 3'b000};
   assign w_lane_b  = w_shifted[7:0];
   assign w_lane_h  = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

   always_comb begin
      o_be    = '0;
      o_wdata = i_store_data;
      o_rdata = i_rdata;
      unique case (1'b1)
         w_byte: begin
            o_be    = 4'b0001 << i_addr;
            o_wdata = {4{i_store_data[7:0]}};
            o_rdata = i_unsigned ? {24'd0, w_lane_b}
                                 : {{24{w_lane_b[7]}}, w_lane_b};
         end
         w_half: begin
            o_be    = i_addr[1] ? 4'b1100 : 4'b0011;
            o_wdata = {2{i_store_data[15:0]}};
            o_rdata = i_unsigned ? {16'd0, w_lane_h}
                                 : {{16{w_lane_h[15]}}, w_lane_h};
         end
         w_word: begin
            o_be    = 4'b1111;
            o_wdata = i_store_data;
            o_rdata = i_rdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage with private little-endian data memory and MEM/WB register.
// Optional MEM_DEBUG_PORT_EN adds a combinational memory dump port.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int NB_DATA     = 32,
   parameter int NB_REG      = 5,
   parameter int NB_MEM_ADDR = DEFAULT_NB_MEM_ADDR
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_halt,
   input  logic [NB_DATA-1:0] i_ALUresult,
   input  logic [NB_DATA-1:0] i_store_data,
   input  logic [NB_REG-1:0]  i_reg2write,
   input  logic               i_memRead,
   input  logic               i_memWrite,
   input  logic [1:0]         i_mem_width,
   input  logic               i_unsigned,
   input  logic               i_mem2reg,
   input  logic               i_regWrite,
   output logic [NB_DATA-1:0] o_reg_read,
   output logic [NB_DATA-1:0] o_ALUresult,
   output logic [NB_REG-1:0]  o_reg2write,
   output logic               o_mem2reg,
   output logic               o_regWrite,
   output logic               o_misaligned
`ifdef MEM_DEBUG_PORT_EN
   ,
   input  logic [NB_MEM_ADDR-1:0] i_dbg_addr,
   output logic [NB_DATA-1:0]     o_dbg_data
`endif
);

   localparam int DEPTH = 2**NB_MEM_ADDR;
   localparam int NB_BE = NB_DATA/8;

   logic [NB_DATA-1:0]     r_mem [DEPTH];
   logic [NB_MEM_ADDR-1:0] w_idx;
   logic [NB_DATA-1:0]     w_word;
   logic [NB_BE-1:0]       w_be;
   logic [NB_DATA-1:0]     w_wdata;
   logic [NB_DATA-1:0]     w_rdata;
   logic                   w_mis;
   logic                   w_we;

   assign w_idx  = i_ALUresult[NB_MEM_ADDR+1:2];
   assign w_word = r_mem[w_idx];

   load_store_align #(
      .NB_DATA (NB_DATA)
   ) u_align (
      .i_addr       (i_ALUresult[1:0]),
      .i_width      (i_mem_width),
      .i_unsigned   (i_unsigned),
      .i_access     (i_memRead | i_memWrite),
      .i_store_data (i_store_data),
      .i_rdata      (w_word),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .o_rdata      (w_rdata),
      .o_misaligned (w_mis)
   );

   assign w_we = i_memWrite && !w_mis && !i_halt && !i_rst;

   always_ff @(posedge i_clk) begin
      if (w_we) begin
         for (int b = 0; b < NB_BE; b++) begin
            if (w_be[b]) begin
               r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
         end
      end
   end

   // Load data comes from the pre-write word when read and write coincide
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_reg_read   <= '0;
         o_ALUresult  <= '0;
         o_reg2write  <= '0;
         o_mem2reg    <= 1'b0;
         o_regWrite   <= 1'b0;
         o_misaligned <= 1'b0;
      end else if (!i_halt) begin
         o_reg_read   <= (i_memRead && !w_mis) ? w_rdata : '0;
         o_ALUresult  <= i_ALUresult;
         o_reg2write  <= i_reg2write;
         o_mem2reg    <= i_mem2reg;
         o_regWrite   <= i_regWrite && !w_mis;
         o_misaligned <= w_mis;
      end
   end

`ifdef MEM_DEBUG_PORT_EN
   assign o_dbg_data = r_mem[i_dbg_addr];
`else
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        halt = 1'b0;
   logic [31:0] alu = '0;
   logic [31:0] sdata = '0;
   logic [4:0]  r2w = '0;
   logic        mrd = 1'b0;
   logic        mwr = 1'b0;
   logic [1:0]  mw = 2'b11;
   logic        uns = 1'b0;
   logic        m2r = 1'b0;
   logic        rw = 1'b0;
   logic [31:0] o_rd;
   logic [31:0] o_alu;
   logic [4:0]  o_r2w;
   logic        o_m2r;
   logic        o_rw;
   logic        o_mis;

   int n_tests = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_access_stage dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_halt       (halt),
      .i_ALUresult  (alu),
      .i_store_data (sdata),
      .i_reg2write  (r2w),
      .i_memRead    (mrd),
      .i_memWrite   (mwr),
      .i_mem_width  (mw),
      .i_unsigned   (uns),
      .i_mem2reg    (m2r),
      .i_regWrite   (rw),
      .o_reg_read   (o_rd),
      .o_ALUresult  (o_alu),
      .o_reg2write  (o_r2w),
      .o_mem2reg    (o_m2r),
      .o_regWrite   (o_rw),
      .o_misaligned (o_mis)
   );

   task automatic drive(input logic [31:0] a, input logic [31:0] d,
                        input logic rd, input logic wr,
                        input logic [1:0] w, input logic u,
                        input logic [4:0] dst, input logic m, input logic r);
      alu = a; sdata = d; mrd = rd; mwr = wr; mw = w; uns = u;
      r2w = dst; m2r = m; rw = r;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(32'h1234, 32'h5678, 1, 0, 2'b11, 0, 5'd7, 1, 1);
      rst = 1'b0;
      n_tests++;
      if (o_rd !== 32'h0 || o_alu !== 32'h0 || o_r2w !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_data: got rd=%h alu=%h r2w=%h expected 0",
                  o_rd, o_alu, o_r2w);
      end
      n_tests++;
      if (o_m2r !== 1'b0 || o_rw !== 1'b0 || o_mis !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got m2r=%b rw=%b mis=%b expected 0",
                  o_m2r, o_rw, o_mis);
      end
   endtask

   task automatic test_word_store_load();
      drive(32'h10, 32'hDEADBEEF, 0, 1, 2'b11, 0, 5'd0, 0, 0);
      drive(32'h10, 32'h0, 1, 0, 2'b11, 1, 5'd5, 1, 1);
      n_tests++;
      if (o_rd !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL word_load: got %h expected DEADBEEF", o_rd);
      end
      n_tests++;
      if (o_rw !== 1'b1 || o_r2w !== 5'd5 || o_m2r !== 1'b1 ||
          o_alu !== 32'h10 || o_mis !== 1'b0) begin
         n_fail++;
         $display("FAIL word_ctrl: got rw=%b r2w=%0d m2r=%b alu=%h mis=%b",
                  o_rw, o_r2w, o_m2r, o_alu, o_mis);
      end
   endtask

   task automatic test_sub_word_loads();
      drive(32'h13, 32'h0, 1, 0, 2'b00, 0, 5'd1, 1, 1);
      n_tests++;
      if (o_rd !== 32'hFFFFFFDE) begin
         n_fail++;
         $display("FAIL lb_13: got %h expected FFFFFFDE", o_rd);
      end
      drive(32'h13, 32'h0, 1, 0, 2'b00, 1, 5'd1, 1, 1);
      n_tests++;
      if (o_rd !== 32'h000000DE) begin
         n_fail++;
         $display("FAIL lbu_13: got %h expected 000000DE", o_rd);
      end
      drive(32'h12, 32'h0, 1, 0, 2'b01, 0, 5'd1, 1, 1);
      n_tests++;
      if (o_rd !== 32'hFFFFDEAD) begin
         n_fail++;
         $display("FAIL lh_12: got %h expected FFFFDEAD", o_rd);
      end
      drive(32'h10, 32'h0, 1, 0, 2'b01, 1, 5'd1, 1, 1);
      n_tests++;
      if (o_rd !== 32'h0000BEEF) begin
         n_fail++;
         $display("FAIL lhu_10: got %h expected 0000BEEF", o_rd);
      end
      drive(32'h11, 32'h0, 1, 0, 2'b00, 0, 5'd1, 1, 1);
      n_tests++;
      if (o_rd !== 32'hFFFFFFBE) begin
         n_fail++;
         $display("FAIL lb_11: got %h expected FFFFFFBE", o_rd);
      end
      drive(32'h10, 32'h0, 1, 0, 2'b10, 0, 5'd1, 1, 1);
      n_tests++;
      if (o_rd !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL lw_w10: got %h expected DEADBEEF", o_rd);
      end
   endtask

   task automatic test_partial_store();
      drive(32'h11, 32'hAAAAAA55, 0, 1, 2'b00, 0, 5'd0, 0, 0);
      drive(32'h10, 32'h0, 1, 0, 2'b11, 0, 5'd2, 1, 1);
      n_tests++;
      if (o_rd !== 32'hDEAD55EF) begin
         n_fail++;
         $display("FAIL sb_11: got %h expected DEAD55EF", o_rd);
      end
      drive(32'h12, 32'hFFFF1234, 0, 1, 2'b01, 0, 5'd0, 0, 0);
      drive(32'h10, 32'h0, 1, 0, 2'b11, 0, 5'd2, 1, 1);
      n_tests++;
      if (o_rd !== 32'h123455EF) begin
         n_fail++;
         $display("FAIL sh_12: got %h expected 123455EF", o_rd);
      end
   endtask

   task automatic test_misaligned();
      drive(32'h12, 32'h0, 1, 0, 2'b11, 0, 5'd4, 1, 1);
      n_tests++;
      if (o_mis !== 1'b1 || o_rw !== 1'b0 || o_rd !== 32'h0) begin
         n_fail++;
         $display("FAIL mis_lw: got mis=%b rw=%b rd=%h expected 1 0 0",
                  o_mis, o_rw, o_rd);
      end
      drive(32'h11, 32'h0, 1, 0, 2'b01, 0, 5'd4, 1, 1);
      n_tests++;
      if (o_mis !== 1'b1 || o_rd !== 32'h0) begin
         n_fail++;
         $display("FAIL mis_lh: got mis=%b rd=%h expected 1 0", o_mis, o_rd);
      end
      drive(32'h12, 32'h0, 0, 1, 2'b11, 0, 5'd0, 0, 0);
      drive(32'h13, 32'h0, 0, 1, 2'b01, 0, 5'd0, 0, 0);
      drive(32'h10, 32'h0, 1, 0, 2'b11, 0, 5'd4, 1, 1);
      n_tests++;
      if (o_rd !== 32'h123455EF || o_mis !== 1'b0 || o_rw !== 1'b1) begin
         n_fail++;
         $display("FAIL mis_store: got rd=%h mis=%b rw=%b expected 123455EF 0 1",
                  o_rd, o_mis, o_rw);
      end
   endtask

   task automatic test_halt();
      drive(32'h777, 32'h0, 0, 0, 2'b11, 0, 5'd3, 0, 1);
      halt = 1'b1;
      drive(32'h10, 32'hCAFEBABE, 0, 1, 2'b11, 0, 5'd9, 1, 1);
      drive(32'h10, 32'h0, 1, 0, 2'b11, 0, 5'd9, 1, 0);
      halt = 1'b0;
      n_tests++;
      if (o_alu !== 32'h777 || o_r2w !== 5'd3 || o_rw !== 1'b1 ||
          o_m2r !== 1'b0 || o_rd !== 32'h0) begin
         n_fail++;
         $display("FAIL halt_hold: got alu=%h r2w=%0d rw=%b m2r=%b rd=%h",
                  o_alu, o_r2w, o_rw, o_m2r, o_rd);
      end
      drive(32'h10, 32'h0, 1, 0, 2'b11, 0, 5'd6, 1, 1);
      n_tests++;
      if (o_rd !== 32'h123455EF || o_r2w !== 5'd6) begin
         n_fail++;
         $display("FAIL halt_nowrite: got rd=%h r2w=%0d expected 123455EF 6",
                  o_rd, o_r2w);
      end
   endtask

   task automatic test_reset_store();
      rst = 1'b1;
      drive(32'h10, 32'h11111111, 0, 1, 2'b11, 0, 5'd8, 1, 1);
      rst = 1'b0;
      n_tests++;
      if (o_alu !== 32'h0 || o_r2w !== 5'd0 || o_rw !== 1'b0 || o_m2r !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_store_out: got alu=%h r2w=%0d rw=%b m2r=%b expected 0",
                  o_alu, o_r2w, o_rw, o_m2r);
      end
      drive(32'h10, 32'h0, 1, 0, 2'b11, 0, 5'd8, 1, 1);
      n_tests++;
      if (o_rd !== 32'h123455EF) begin
         n_fail++;
         $display("FAIL rst_store_drop: got %h expected 123455EF", o_rd);
      end
   endtask

   task automatic test_wrap();
      drive(32'h400, 32'hA5A50001, 0, 1, 2'b11, 0, 5'd0, 0, 0);
      drive(32'h0, 32'h0, 1, 0, 2'b11, 0, 5'd1, 1, 1);
      n_tests++;
      if (o_rd !== 32'hA5A50001) begin
         n_fail++;
         $display("FAIL wrap: got %h expected A5A50001", o_rd);
      end
      drive(32'h3FC, 32'h0, 1, 0, 2'b11, 0, 5'd1, 1, 1);
      n_tests++;
      if (o_rd !== 32'h0) begin
         n_fail++;
         $display("FAIL wrap_top: got %h expected 00000000 (unwritten word read back only if aliased)", o_rd);
      end
   endtask

   task automatic test_read_write_both();
      drive(32'h10, 32'h0BADF00D, 1, 1, 2'b11, 0, 5'd2, 1, 1);
      n_tests++;
      if (o_rd !== 32'h123455EF) begin
         n_fail++;
         $display("FAIL rw_both_old: got %h expected 123455EF", o_rd);
      end
      drive(32'h10, 32'h0, 1, 0, 2'b11, 0, 5'd2, 1, 1);
      n_tests++;
      if (o_rd !== 32'h0BADF00D) begin
         n_fail++;
         $display("FAIL rw_both_new: got %h expected 0BADF00D", o_rd);
      end
   endtask

   initial begin
      test_reset();
      test_word_store_load();
      test_sub_word_loads();
      test_partial_store();
      test_misaligned();
      test_halt();
      test_reset_store();
      test_read_write_both();
      drive(32'h3FC, 32'h0, 0, 1, 2'b11, 0, 5'd0, 0, 0);
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM stage of the 5-stage MIPS pipeline, together with the MEM/WB pipeline register. It takes EX/MEM results, performs loads and stores on a private byte-addressed, little-endian data memory, and registers everything the write-back stage consumes. It sits between the execute stage and the write-back mux.

Parameters:
NB_DATA, 32, datapath width
NB_REG, 5, register-index width
NB_MEM_ADDR, 8, word-index bits; memory depth = 2**NB_MEM_ADDR words

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_halt  in  1  stage stall from debug unit; freezes memory writes and the output register
i_ALUresult  in  NB_DATA  byte address for loads/stores; pass-through value for ALU ops
i_store_data  in  NB_DATA  rt value to store
i_reg2write  in  NB_REG  destination register
i_memRead  in  1  load
i_memWrite  in  1  store
i_mem_width  in  2  00 byte, 01 half, 11 word; 10 treated as word
i_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend loads
i_mem2reg  in  1  forwarded control
i_regWrite  in  1  forwarded control
o_reg_read  out  NB_DATA  registered, extended load data
o_ALUresult  out  NB_DATA  registered ALU result
o_reg2write  out  NB_REG  registered destination register
o_mem2reg  out  1  registered control
o_regWrite  out  1  registered control, gated by misalignment
o_misaligned  out  1  registered alignment fault flag

Behaviour:
- Reset (i_rst sampled high on i_clk edge): all outputs go to 0. Memory contents are not reset. Reset has priority over i_halt and suppresses any store in the same cycle.
- Address decode:
  - word index = i_ALUresult[NB_MEM_ADDR+1:2]
  - higher address bits are ignored (address wraps)
  - byte lane = i_ALUresult[1:0]
- Misaligned access:
  - half access with addr[0]=1, or word access with addr[1:0]!=0
  - applies only when i_memRead or i_memWrite is set
- Store (i_memWrite=1, aligned, !i_halt, !i_rst): written at the i_clk edge.
  - Byte: store_data[7:0] goes to lane addr[1:0].
  - Half: store_data[15:0] goes to lanes {addr[1],0}+1 : {addr[1],0}.
  - Word: the full word is written.
  - Other lanes are untouched.
- Load path:
  - Asynchronous read of the addressed word, lane select, then extension per i_unsigned.
  - The result is latched into o_reg_read at the edge.
  - Total latency: 1 cycle from input to outputs.
  - Store at edge N followed by a load of the same address at edge N+1 returns the new data.
- i_memRead=0: o_reg_read latches 0.
- Misaligned access:
  - Store is suppressed.
  - o_reg_read latches 0.
  - o_regWrite latches 0.
  - o_misaligned latches 1 for that one cycle.
- i_memRead and i_memWrite both high: treated as a store. o_reg_read returns the pre-write word.
- i_halt=1: all output registers hold their values and no store occurs. The state is fully resumable when i_halt drops.
- Non-memory ops: o_ALUresult, o_reg2write, o_mem2reg and o_regWrite latch their inputs unchanged.

Optional Feature:
MEM_DEBUG_PORT_EN
- Defined: adds i_dbg_addr (NB_MEM_ADDR, word index) and o_dbg_data (NB_DATA). o_dbg_data is a combinational read of the word at i_dbg_addr, independent of i_halt, so the UART debug unit can dump memory.
- Undefined: neither port exists and there is no extra logic.

Decomposition:
- Shared package: width encodings MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b11, and the default depth constant.
- One natural sub-module, load_store_align: a combinational unit that produces per-byte write enables, the shifted store data, extended load data and the misaligned flag.
- The parent holds the memory array and the MEM/WB register.

Test Plan:
- Word store 0xDEADBEEF at addr 0x10, then unsigned word load of 0x10 -> o_reg_read=0xDEADBEEF one cycle later; o_regWrite follows the input.
- After the above, byte load of addr 0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE. Half load of addr 0x12 signed -> 0xFFFFDEAD.
- Byte store 0x55 to addr 0x11, then word load of 0x10 -> 0xDEAD55EF (other lanes preserved).
- Word load at addr 0x12 with i_regWrite=1 -> o_misaligned=1, o_regWrite=0, o_reg_read=0; memory unchanged.
- i_halt=1 during a store with i_regWrite=1 -> outputs hold their previous values and a later load shows no write.
- i_rst=1 concurrent with a store -> all outputs 0 next cycle and the store is dropped.
- Address wraparound -> address 0x400 with NB_MEM_ADDR=8 aliases 0x000.
